// File: rtl/cpu_pkg.sv
// =====================================================================
// cpu_pkg : opcode constants, ALU select codes and datapath sizes
// Rev 1.0
// =====================================================================
`default_nettype none

package cpu_pkg;

  localparam int unsigned DATA_W   = 8;
  localparam int unsigned ADDR_W   = 3;
  localparam int unsigned NUM_REGS = 8;

  localparam logic [7:0] OP_LOADI = 8'h00;
  localparam logic [7:0] OP_MOV   = 8'h01;
  localparam logic [7:0] OP_ADD   = 8'h02;
  localparam logic [7:0] OP_SUB   = 8'h03;
  localparam logic [7:0] OP_AND   = 8'h04;
  localparam logic [7:0] OP_OR    = 8'h05;

  typedef enum logic [2:0] {
    ALU_FORWARD = 3'b000,
    ALU_ADD     = 3'b001,
    ALU_AND     = 3'b010,
    ALU_OR      = 3'b011
  } alu_sel_e;

endpackage

`default_nettype wire

// File: rtl/cpu_reg_file.sv
// =====================================================================
// reg_file : 8 x 8-bit registers, two async read ports, one sync write
// Rev 1.0
// =====================================================================
`default_nettype none

module reg_file
  import cpu_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr1_i,
  input  logic [ADDR_W-1:0] raddr2_i,
  output logic [DATA_W-1:0] rdata1_o,
  output logic [DATA_W-1:0] rdata2_o
);

  logic [DATA_W-1:0] registers [0:NUM_REGS-1];

  // Reads see the pre-edge contents, so a source equal to the destination gets the old value.
  assign rdata1_o = registers[raddr1_i];
  assign rdata2_o = registers[raddr2_i];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        registers[i] <= '0;
      end
    end else if (we_i) begin
      registers[waddr_i] <= wdata_i;
    end
  end

endmodule

`default_nettype wire

// File: rtl/cpu.sv
// =====================================================================
// cpu : single-cycle 8-bit CPU, one instruction per clock, PC steps by 4
// Rev 1.0
// =====================================================================
`default_nettype none

module cpu
  import cpu_pkg::*;
(
  output logic [31:0] PC,
  input  logic [31:0] INSTRUCTION,
  input  logic        CLK,
  input  logic        RESET
);

  logic [31:0]       pc_q;
  logic [31:0]       pc_d;
  logic [7:0]        opcode;
  logic [ADDR_W-1:0] dest;
  logic [ADDR_W-1:0] src1;
  logic [ADDR_W-1:0] src2;
  logic [DATA_W-1:0] imm;
  logic              unused_fields;

  alu_sel_e          alu_sel;
  logic              use_imm;
  logic              negate;
  logic              reg_we;

  logic [DATA_W-1:0] rdata1;
  logic [DATA_W-1:0] rdata2;
  logic [DATA_W-1:0] rdata2_neg;
  logic [DATA_W-1:0] operand_b;
  logic [DATA_W-1:0] alu_result;

  // PC logic
  always_comb pc_d = pc_q + 32'd4;

  always_ff @(posedge CLK) begin
    if (RESET) pc_q <= '0;
    else       pc_q <= pc_d;
  end

  assign PC = pc_q;

  // Field extraction; only the low three bits of the register fields are used.
  assign opcode        = INSTRUCTION[31:24];
  assign dest          = INSTRUCTION[18:16];
  assign src1          = INSTRUCTION[10:8];
  assign src2          = INSTRUCTION[2:0];
  assign imm           = INSTRUCTION[7:0];
  assign unused_fields = ^{INSTRUCTION[23:19], INSTRUCTION[15:11]};

  always_comb begin
    alu_sel = ALU_FORWARD;
    use_imm = 1'b0;
    negate  = 1'b0;
    reg_we  = 1'b0;
    case (opcode)
      OP_LOADI: begin use_imm = 1'b1;                        reg_we = 1'b1; end
      OP_MOV:   begin                                        reg_we = 1'b1; end
      OP_ADD:   begin alu_sel = ALU_ADD;                     reg_we = 1'b1; end
      OP_SUB:   begin alu_sel = ALU_ADD; negate = 1'b1;      reg_we = 1'b1; end
      OP_AND:   begin alu_sel = ALU_AND;                     reg_we = 1'b1; end
      OP_OR:    begin alu_sel = ALU_OR;                      reg_we = 1'b1; end
      default:  ;
    endcase
  end

  // Subtraction reuses the adder with the two's complement of the second operand.
  assign rdata2_neg = ~rdata2 + 8'd1;
  assign operand_b  = use_imm ? imm : (negate ? rdata2_neg : rdata2);

  always_comb begin
    alu_result = operand_b;
    case (alu_sel)
      ALU_FORWARD: alu_result = operand_b;
      ALU_ADD:     alu_result = rdata1 + operand_b;
      ALU_AND:     alu_result = rdata1 & operand_b;
      ALU_OR:      alu_result = rdata1 | operand_b;
      default:     alu_result = operand_b;
    endcase
  end

  reg_file REGFILE (
    .clk_i    (CLK),
    .rst_i    (RESET),
    .we_i     (reg_we & ~RESET),
    .waddr_i  (dest),
    .wdata_i  (alu_result),
    .raddr1_i (src1),
    .raddr2_i (src2),
    .rdata1_o (rdata1),
    .rdata2_o (rdata2)
  );

endmodule

`default_nettype wire

// File: tb/tb_cpu.sv
// =====================================================================
// tb_cpu : directed program with an instruction-level reference model
// Rev 1.0
// =====================================================================
`default_nettype none

module tb_cpu;

  logic [31:0] PC;
  logic [31:0] INSTRUCTION;
  logic        CLK;
  logic        RESET;

  logic [31:0] mem [0:31];

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] m_pc;
  logic [7:0]  m_r [0:7];
  bit          model_valid = 1'b0;

  cpu dut (
    .PC          (PC),
    .INSTRUCTION (INSTRUCTION),
    .CLK         (CLK),
    .RESET       (RESET)
  );

  assign INSTRUCTION = mem[PC[6:2]];

  initial CLK = 1'b0;
  always #4 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Instruction-level reference: one architectural step per rising edge.
  always @(posedge CLK) begin
    logic [31:0] ins;
    int a, b, d, res;
    if (RESET) begin
      m_pc = 32'd0;
      for (int i = 0; i < 8; i++) m_r[i] = 8'd0;
      model_valid = 1'b1;
    end else if (model_valid) begin
      ins = mem[m_pc[6:2]];
      d   = int'(ins[18:16]);
      a   = int'(m_r[ins[10:8]]);
      b   = int'(m_r[ins[2:0]]);
      res = -1;
      case (ins[31:24])
        8'h00: res = int'(ins[7:0]);
        8'h01: res = b;
        8'h02: res = (a + b) % 256;
        8'h03: res = (a - b + 256) % 256;
        8'h04: res = a & b;
        8'h05: res = a | b;
        default: res = -1;
      endcase
      if (res >= 0) m_r[d] = res[7:0];
      m_pc = m_pc + 32'd4;
    end
  end

  always @(negedge CLK) begin
    if (model_valid) begin
      check("pc_model", PC, m_pc);
      for (int i = 0; i < 8; i++)
        check($sformatf("r%0d_model", i), {24'd0, dut.REGFILE.registers[i]}, {24'd0, m_r[i]});
    end
  end

  function automatic logic [31:0] rg(input int idx);
    return {24'd0, dut.REGFILE.registers[idx]};
  endfunction

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'hFF000000;
    mem[0]  = 32'h00040005; // loadi r4,5
    mem[1]  = 32'h00020009; // loadi r2,9
    mem[2]  = 32'h02060402; // add r6,r4,r2
    mem[3]  = 32'h00010003; // loadi r1,3
    mem[4]  = 32'h03030201; // sub r3,r2,r1
    mem[5]  = 32'h03000102; // sub r0,r1,r2
    mem[6]  = 32'h0004000C; // loadi r4,0x0C
    mem[7]  = 32'h0002000A; // loadi r2,0x0A
    mem[8]  = 32'h04050402; // and r5,r4,r2
    mem[9]  = 32'h05070402; // or  r7,r4,r2
    mem[10] = 32'h01010007; // mov r1,r7
    mem[11] = 32'h000300FF; // loadi r3,0xFF
    mem[12] = 32'h00060002; // loadi r6,2
    mem[13] = 32'h02000306; // add r0,r3,r6
    mem[14] = 32'h07010203; // undefined opcode
    mem[15] = 32'h02040404; // add r4,r4,r4
    mem[16] = 32'h02020203; // add r2,r2,r3 (interrupted by reset)

    RESET = 1'b0;
    #2 RESET = 1'b1;
    #4 RESET = 1'b0;

    @(negedge CLK);                     // t=8
    check("reset_pc", PC, 32'd0);
    check("reset_r4", rg(4), 32'h00);
    @(negedge CLK); check("fetch_pc4", PC, 32'd4);  check("loadi_r4", rg(4), 32'h05);
    @(negedge CLK); check("fetch_pc8", PC, 32'd8);  check("loadi_r2", rg(2), 32'h09);
    @(negedge CLK); check("fetch_pc12", PC, 32'd12); check("add_r6", rg(6), 32'h0E);
    repeat (3) @(negedge CLK);
    check("sub_r3", rg(3), 32'h06);
    check("sub_r0", rg(0), 32'hFA);
    repeat (5) @(negedge CLK);
    check("and_r5", rg(5), 32'h08);
    check("or_r7",  rg(7), 32'h0E);
    check("mov_r1", rg(1), 32'h0E);
    repeat (3) @(negedge CLK);
    check("ovf_r0", rg(0), 32'h01);
    @(negedge CLK);
    check("nop_pc", PC, 32'd60);
    check("nop_r0", rg(0), 32'h01);
    check("nop_r3", rg(3), 32'hFF);
    @(negedge CLK);
    check("same_src_dest_r4", rg(4), 32'h18);

    check("pre_reset_pc", PC, 32'd64);
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    check("midreset_pc", PC, 32'd0);
    check("midreset_r2", rg(2), 32'h00);
    check("midreset_r4", rg(4), 32'h00);
    @(negedge CLK);
    check("restart_pc", PC, 32'd4);
    check("restart_r4", rg(4), 32'h05);

    RESET = 1'b1;
    repeat (3) begin
      @(negedge CLK);
      check("hold_reset_pc", PC, 32'd0);
    end
    RESET = 1'b0;
    @(negedge CLK);
    check("release_pc", PC, 32'd4);
    check("release_r4", rg(4), 32'h05);
    @(negedge CLK);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/cpu.md
CPU -- requirements
Module: cpu

Interface
REQ-001 SHALL have ports, in this order: PC, INSTRUCTION, CLK, RESET.
REQ-002 CLK  input  1  system clock; all state updates occur on its rising edge.
REQ-003 RESET  input  1  synchronous, active-high reset, sampled on the CLK rising edge.
REQ-004 PC  output  32  byte address of the current instruction; drives an external instruction memory.
REQ-005 INSTRUCTION  input  32  instruction word for the current PC, returned combinationally by the memory 2 time units after PC changes.

Function
REQ-006 Instruction fields SHALL be: OPCODE[31:24], DEST[23:16] (low 3 bits used), SRC1/RT[15:8] (low 3 bits), SRC2/IMM[7:0] (low 3 bits as register index, full 8 bits as immediate).
REQ-007 Opcodes SHALL be: 0x00 loadi (rd = IMM), 0x01 mov (rd = r[src2]), 0x02 add (rd = r[src1] + r[src2]), 0x03 sub (rd = r[src1] - r[src2]), 0x04 and, 0x05 or.
REQ-008 Any other opcode SHALL be a no-op: no register write, PC still advances.
REQ-009 Datapath width SHALL be 8 bits; add/sub wrap modulo 256; no flags or carry out.
REQ-010 sub SHALL be computed as r[src1] + (two's complement of r[src2]).
REQ-011 The register file SHALL be 8 x 8-bit, with two asynchronous read ports and one synchronous write port.
REQ-012 Write-back SHALL occur on the rising edge that ends the instruction's cycle; the result SHALL be visible to the next instruction.
REQ-013 Exactly one instruction SHALL execute per clock cycle; there is no pipeline, stall or hazard logic.
REQ-014 On each rising edge without reset, PC SHALL update to PC + 4 (32-bit, wrapping).
REQ-015 Simulation delays (time units) SHALL be:
- PC register update: 1
- PC+4 adder: 1
- decode: 1
- register read: 2
- register write: 1
- two's-complement negate: 1
- ALU forward/and/or: 1
- ALU add: 2
REQ-016 With these delays, all operands and results SHALL settle within an 8-unit clock period.
REQ-017 Writes to any register index, including r0, SHALL be permitted.
REQ-018 A source register equal to DEST SHALL read the old value; the new value is written at the edge.

Reset
REQ-019 On a rising edge with RESET=1, PC SHALL become 0x00000000 (after the 1-unit update delay).
REQ-020 On that edge, all eight registers SHALL be cleared to 0x00.
REQ-021 On that edge, any pending register write SHALL be suppressed.
REQ-022 RESET held high over several edges SHALL keep PC at 0; on the first edge after release, the instruction at address 0 SHALL complete and PC SHALL become 4.
REQ-023 Asserting RESET mid-program SHALL abandon the current instruction with no write-back.

Structure
REQ-024 A shared package SHALL hold the opcode constants and ALU select codes: FORWARD=000, ADD=001, AND=010, OR=011.
REQ-025 The register file SHALL be a sub-module named reg_file, instantiated as REGFILE, with its storage an array named registers[0:7] so it is visible hierarchically.
REQ-026 The ALU, control decode, PC logic and negation SHALL be separate always/assign blocks or small modules inside cpu.

Verification
REQ-027 Reset and fetch: RESET high from t=2 to t=6 with an 8-unit clock -> PC=0 after the edge at t=4; PC=4, 8, 12 on successive edges.
REQ-028 Immediates and add: program loadi r4,5; loadi r2,9; add r6,r4,r2 (encodings 0x00040005, 0x00020009, 0x02060402) -> r4=0x05, r2=0x09, r6=0x0E.
REQ-029 Subtract: program loadi r1,3; sub r3,r2,r1; sub r0,r1,r2 (r2=9) -> r3=0x06, r0=0xFA.
REQ-030 Logic and move: r4=0x0C, r2=0x0A, then and r5,r4,r2; or r7,r4,r2; mov r1,r7 -> r5=0x08, r7=0x0E, r1=0x0E.
REQ-031 Overflow and undefined opcode: loadi 0xFF and 0x02, add -> 0x01; then opcode 0x07 -> all registers unchanged, PC advances by 4.
REQ-032 Mid-run reset: one-cycle RESET pulse during an add -> destination register stays 0x00, PC restarts at 0.
